// File: rtl/inst_queue_if.sv
// Fetch-side and issue-side signals of the instruction queue.
// The queue itself is the slave; IF/ID together act as the master.
interface inst_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              flush;
    logic              in_valid;
    logic [31:0]       in_pc;
    logic [63:0]       in_rdata;
    logic              in_ready;
    logic [1:0]        deq;
    logic              out1_valid;
    logic [31:0]       out1_pc;
    logic [31:0]       out1_inst;
    logic              out2_valid;
    logic [31:0]       out2_pc;
    logic [31:0]       out2_inst;
    logic [PTR_W:0]    count;

    modport master (
        output flush, in_valid, in_pc, in_rdata, deq,
        input  in_ready, out1_valid, out1_pc, out1_inst,
               out2_valid, out2_pc, out2_inst, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_rdata, deq,
        output in_ready, out1_valid, out1_pc, out1_inst,
               out2_valid, out2_pc, out2_inst, count
    );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction fetch queue: one 64-bit fetch group in per cycle,
// the two oldest instructions presented to a dual-issue decode stage.
module inst_queue #(
    parameter int DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    inst_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       deq_c;
    logic [1:0]       eff_deq;
    logic [1:0]       push_n;
    logic             push;
    logic             ready;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Ready comes from the registered count only, never from this cycle's deq.
    assign ready = (cnt <= CNT_W'(DEPTH - 2));
    assign push  = q.in_valid & ready & ~q.flush;

    always_comb begin
        push_n = 2'd0;
        if (push) begin
            push_n = q.in_pc[2] ? 2'd1 : 2'd2;
        end
    end

    // deq is clamped to what is actually held so pointers never overrun.
    always_comb begin
        deq_c   = (q.deq == 2'd3) ? 2'd2 : q.deq;
        eff_deq = deq_c;
        if (CNT_W'(deq_c) > cnt) begin
            eff_deq = cnt[1:0];
        end
    end

    assign cnt_next = cnt + CNT_W'(push_n) - CNT_W'(eff_deq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (q.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                pc_mem[tail] <= q.in_pc;
                if (q.in_pc[2]) begin
                    inst_mem[tail] <= q.in_rdata[63:32];
                end else begin
                    inst_mem[tail]   <= q.in_rdata[31:0];
                    pc_mem[tail_p1]  <= q.in_pc + 32'd4;
                    inst_mem[tail_p1] <= q.in_rdata[63:32];
                end
            end
            tail <= tail + PTR_W'(push_n);
            head <= head + PTR_W'(eff_deq);
            cnt  <= cnt_next;
        end
    end

    assign q.in_ready   = ready;
    assign q.count      = cnt;
    assign q.out1_valid = (cnt >= CNT_W'(1));
    assign q.out2_valid = (cnt >= CNT_W'(2));
    assign q.out1_pc    = q.out1_valid ? pc_mem[head]      : 32'd0;
    assign q.out1_inst  = q.out1_valid ? inst_mem[head]    : 32'd0;
    assign q.out2_pc    = q.out2_valid ? pc_mem[head_p1]   : 32'd0;
    assign q.out2_inst  = q.out2_valid ? inst_mem[head_p1] : 32'd0;
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction fetch queue between the IF/instruction-SRAM return path and the dual-issue ID stage. Each cycle it accepts one 64-bit fetch group (one or two 32-bit instructions, depending on PC alignment), buffers the instructions with their PCs in a circular FIFO, and presents the two oldest entries to ID. ID consumes zero, one or two instructions per cycle. Fetch and decode are decoupled this way so that scoreboard stalls and single-issue cycles do not throw away fetched instructions. A branch redirect flushes the queue.

## Interface
- DEPTH, 8, number of instruction entries; power of two, ≥ 4
- PTR_W, $clog2(DEPTH), pointer width (derived)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  branch/redirect taken; discard all contents
- in_valid  in  1  fetch group present on in_pc/in_rdata
- in_pc  in  32  fetch PC; in_pc[1:0]=0
- in_rdata  in  64  [31:0] = inst at {in_pc[31:3],3'b000}, [63:32] = inst at {in_pc[31:3],3'b100}
- in_ready  out  1  queue can accept a full group (free ≥ 2)
- deq  in  2  instructions consumed by ID this cycle (0, 1, 2; 3 illegal)
- out1_valid  out  1  oldest entry present
- out1_pc  out  32  PC of oldest entry
- out1_inst  out  32  oldest instruction
- out2_valid  out  1  second-oldest entry present
- out2_pc  out  32  PC of second entry
- out2_inst  out  32  second instruction
- count  out  PTR_W+1  occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH × {pc[31:0], inst[31:0]} registers, head/tail pointers of width PTR_W, and a count register of width PTR_W+1.
- A push happens when in_valid & in_ready & ~flush.
  - in_pc[2]=0: write two entries in order, {in_pc, in_rdata[31:0]} then {in_pc+4, in_rdata[63:32]}. tail += 2.
  - in_pc[2]=1: write one entry, {in_pc, in_rdata[63:32]}. tail += 1.
- in_valid while in_ready=0 is dropped. IF is responsible for holding its PC.
- Pop: head += eff_deq, where eff_deq = min(deq, count). deq>count is a protocol error; the bench asserts on it and the RTL clamps.
- Push and pop in the same cycle are both applied: count_next = count + pushed − eff_deq.
- Pointers wrap modulo DEPTH. A two-entry push may straddle the wrap (entries DEPTH−1 and 0).
- flush has priority over push and deq. Next cycle: head=tail=0, count=0. Storage contents are don't-care.
- Outputs are combinational reads of registered state:
  - out1_* = entry[head], out1_valid = (count≥1)
  - out2_* = entry[head+1 mod DEPTH], out2_valid = (count≥2)
  - When an outN_valid is 0, its pc/inst are forced to 0.
- in_ready = (count ≤ DEPTH−2), taken from the registered count only. It does not depend on deq in the same cycle, so there is no combinational path from deq to in_ready.
- Program order is always preserved. out1 is always older than out2.

## Timing
- Reset (asynchronous assert, synchronous use after deassert):
  - head=tail=0, count=0, storage=0.
  - out1_valid=out2_valid=0, all out pc/inst=0, in_ready=1, count=0.
- Push-to-visible latency is 1 cycle. A group written at edge N appears on out1/out2 after edge N.
- There is no same-cycle bypass from in_* to out_*.
- A deq issued in cycle N shifts the outputs after edge N.
- Flush in cycle N: queue is empty after edge N. A push presented in cycle N is lost. The first post-redirect group can be pushed in cycle N+1.
- Reset asserted mid-operation clears immediately, independent of clk.

## Test plan
- Reset mid-run: count=5, assert reset between edges → count=0, out1_valid=out2_valid=0, in_ready=1 without waiting for a clock edge.
- Aligned push: in_pc=0xBFC00000, in_rdata=0x24020002_24010001, deq=0 → next cycle out1=(0xBFC00000, 0x24010001), out2=(0xBFC00004, 0x24020002), count=2.
- Unaligned push: in_pc=0xBFC00014, in_rdata=0x8C430000_AC220000 → out1=(0xBFC00014, 0x8C430000), out2_valid=0, count=1.
- Full: DEPTH=8, four aligned pushes with deq=0 → count=8, in_ready=0. A fifth in_valid is ignored. Then deq=1 → count=7, in_ready stays 0. Then deq=1 → count=6, in_ready=1.
- Streaming and wrap: keep count=2, then push 2 and deq=2 every cycle for 10 cycles with PCs 0xBFC00000+8k → count stays 2. Out PCs increase by exactly 4 in order across the tail/head wrap, with no gaps or duplicates.
- Flush collision: count=4 with in_valid=1, deq=2 and flush=1 in the same cycle → next cycle count=0, both out valids 0. A pushed group at 0xBFC00100 in the following cycle appears at out1.
